// File: rtl/gen_reg_bank_pkg.sv
// Shared definitions for the general-register bank: widths, strobe codes, FSM states.
package gr_defs;

    localparam int DATA_W = 16;
    localparam int NREG   = 6;
    localparam int IDX_W  = 3;

    // One-hot strobe codes: the MSB selects R0, the LSB selects R5.
    localparam logic [NREG-1:0] GR_R0   = 6'b100000;
    localparam logic [NREG-1:0] GR_R1   = 6'b010000;
    localparam logic [NREG-1:0] GR_R2   = 6'b001000;
    localparam logic [NREG-1:0] GR_R3   = 6'b000100;
    localparam logic [NREG-1:0] GR_R4   = 6'b000010;
    localparam logic [NREG-1:0] GR_R5   = 6'b000001;
    localparam logic [NREG-1:0] GR_NONE = 6'b000000;

    typedef enum logic {
        GR_IDLE  = 1'b0,
        GR_WRITE = 1'b1
    } gr_state_t;

endpackage

// File: rtl/gen_reg_bank_if.sv
// Strobe/bus/debug bundle between the control unit (master) and the register bank (slave).
interface gen_reg_bank_if;
    import gr_defs::*;

    logic [NREG-1:0]   rxOut;
    logic [NREG-1:0]   rxIn;
    logic [DATA_W-1:0] bus_in;
    logic [DATA_W-1:0] bus_out;
    logic              bus_drv;
    logic              wr_ack;
    logic              err;
    logic              err_clr;
    logic [IDX_W-1:0]  dbg_sel;
    logic [DATA_W-1:0] dbg_data;

    modport master (
        output rxOut, rxIn, bus_in, err_clr, dbg_sel,
        input  bus_out, bus_drv, wr_ack, err, dbg_data
    );

    modport slave (
        input  rxOut, rxIn, bus_in, err_clr, dbg_sel,
        output bus_out, bus_drv, wr_ack, err, dbg_data
    );

endinterface

// File: rtl/gr_onehot_chk.sv
// Classifies a strobe as exactly-one-hot, all-zero or neither, and decodes the
// register index (MSB -> index 0, LSB -> index N-1).
module gr_onehot_chk
    import gr_defs::*;
#(
    parameter int N = NREG
) (
    input  logic [N-1:0]     strobe,
    output logic             valid,
    output logic             zero,
    output logic [IDX_W-1:0] index
);

    // Population test plus priority-free decode; index is only meaningful when valid.
    always_comb begin
        zero  = (strobe == '0);
        valid = !zero && ((strobe & (strobe - N'(1))) == '0);
        index = '0;
        for (int i = 0; i < N; i++) begin
            if (strobe[i]) index = IDX_W'(N - 1 - i);
        end
    end

endmodule

// File: rtl/gen_reg_bank.sv
// General-register bank: one-hot read/write strobes, write-ack FSM, sticky error flag
// and a side-effect-free debug read port.
module gen_reg_bank
    import gr_defs::*;
(
    input  logic          clk,
    input  logic          rst,
    gen_reg_bank_if.slave bus
);

    logic [NREG-1:0][DATA_W-1:0] regs;
    logic [NREG-1:0]             last_in;
    gr_state_t                   state, state_nxt;
    logic                        ack_nxt;
    logic                        err_set;

    logic             out_valid, out_zero, in_valid, in_zero;
    logic [IDX_W-1:0] out_idx, in_idx;
    logic             out_multi, in_multi;

    gr_onehot_chk #(.N(NREG)) u_out_chk (
        .strobe (bus.rxOut),
        .valid  (out_valid),
        .zero   (out_zero),
        .index  (out_idx)
    );

    gr_onehot_chk #(.N(NREG)) u_in_chk (
        .strobe (bus.rxIn),
        .valid  (in_valid),
        .zero   (in_zero),
        .index  (in_idx)
    );

    assign out_multi = !out_valid && !out_zero;
    assign in_multi  = !in_valid && !in_zero;
    assign err_set   = out_multi || in_multi;

    // Read path: drive the selected register only for a clean one-hot rxOut.
    always_comb begin
        bus.bus_out = '0;
        bus.bus_drv = out_valid;
        for (int i = 0; i < NREG; i++) begin
            if (out_valid && out_idx == IDX_W'(i)) bus.bus_out = regs[i];
        end
    end

    // Debug read: out-of-range indices read as zero.
    always_comb begin
        bus.dbg_data = '0;
        for (int i = 0; i < NREG; i++) begin
            if (bus.dbg_sel == IDX_W'(i)) bus.dbg_data = regs[i];
        end
    end

    // Register file: capture bus_in every cycle a clean one-hot rxIn is present.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            regs <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (in_valid && in_idx == IDX_W'(i)) regs[i] <= bus_in_q(i);
            end
        end
    end

    function automatic logic [DATA_W-1:0] bus_in_q(input int i);
        bus_in_q = (i >= 0) ? bus.bus_in : '0;
    endfunction

    // Sticky error: a new violation in the same cycle as err_clr keeps the flag set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)             bus.err <= 1'b0;
        else if (err_set)     bus.err <= 1'b1;
        else if (bus.err_clr) bus.err <= 1'b0;
    end

    // Ack FSM state, registered ack pulse and the strobe it was issued for.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= GR_IDLE;
            bus.wr_ack <= 1'b0;
            last_in    <= GR_NONE;
        end else begin
            state      <= state_nxt;
            bus.wr_ack <= ack_nxt;
            if (in_valid) last_in <= bus.rxIn;
        end
    end

    // Ack FSM: one ack per new write target; a held strobe does not re-ack.
    always_comb begin
        state_nxt = state;
        ack_nxt   = 1'b0;
        case (state)
            GR_IDLE: begin
                if (in_valid) begin
                    state_nxt = GR_WRITE;
                    ack_nxt   = 1'b1;
                end
            end
            GR_WRITE: begin
                if (in_zero || in_multi) state_nxt = GR_IDLE;
                else if (bus.rxIn != last_in) ack_nxt = 1'b1;
            end
            default: state_nxt = GR_IDLE;
        endcase
    end

endmodule

// File: tb/tb_gen_reg_bank.sv
// Directed bench for gen_reg_bank: reset, write/read, MOV, held strobe, errors,
// same-register read/write, debug port and reset during a write.
module tb_gen_reg_bank;
    import gr_defs::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   acks;

    gen_reg_bank_if bif ();

    gen_reg_bank u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic dbg(input string tag, input logic [IDX_W-1:0] sel, input logic [DATA_W-1:0] exp);
        bif.dbg_sel = sel;
        #1;
        chk(tag, 32'(bif.dbg_data), 32'(exp));
    endtask

    initial begin
        bif.rxOut   = GR_NONE;
        bif.rxIn    = GR_NONE;
        bif.bus_in  = '0;
        bif.err_clr = 1'b0;
        bif.dbg_sel = '0;

        // 1: reset state
        #2;
        for (int i = 0; i < NREG; i++) dbg($sformatf("rst_r%0d", i), IDX_W'(i), 16'h0000);
        chk("rst_drv",  32'(bif.bus_drv), 0);
        chk("rst_bus",  32'(bif.bus_out), 0);
        chk("rst_ack",  32'(bif.wr_ack), 0);
        chk("rst_err",  32'(bif.err), 0);
        #3 rst = 1'b1;
        tick();

        // 2: write R2 then read it back
        bif.bus_in = 16'hA5C3; bif.rxIn = GR_R2;
        tick();
        chk("wr_ack", 32'(bif.wr_ack), 1);
        bif.rxIn = GR_NONE; bif.rxOut = GR_R2;
        #1;
        chk("rd_bus", 32'(bif.bus_out), 32'hA5C3);
        chk("rd_drv", 32'(bif.bus_drv), 1);
        tick();
        chk("wr_ack_drop", 32'(bif.wr_ack), 0);
        bif.rxOut = GR_NONE;

        // 3: MOV R4 -> R0 with bus_in looped from bus_out
        bif.bus_in = 16'h1234; bif.rxIn = GR_R4;
        tick();
        bif.rxIn = GR_NONE;
        tick();
        acks = 0;
        bif.rxOut = GR_R4;
        #1 bif.bus_in = bif.bus_out;
        tick(); acks += int'(bif.wr_ack);
        bif.rxIn = GR_R0;
        #1 bif.bus_in = bif.bus_out;
        tick(); acks += int'(bif.wr_ack);
        bif.rxIn = GR_NONE; bif.rxOut = GR_NONE;
        tick(); acks += int'(bif.wr_ack);
        chk("mov_acks", 32'(acks), 1);
        dbg("mov_r0", 3'd0, 16'h1234);

        // 4: held strobe on R5, then switch to R3
        bif.rxIn = GR_R5; bif.bus_in = 16'h0111;
        tick();
        chk("hold_ack1", 32'(bif.wr_ack), 1);
        dbg("hold_r5a", 3'd5, 16'h0111);
        bif.bus_in = 16'h0222;
        tick();
        chk("hold_ack2", 32'(bif.wr_ack), 0);
        dbg("hold_r5b", 3'd5, 16'h0222);
        bif.bus_in = 16'h0333;
        tick();
        chk("hold_ack3", 32'(bif.wr_ack), 0);
        dbg("hold_r5c", 3'd5, 16'h0333);
        bif.rxIn = GR_R3; bif.bus_in = 16'h0444;
        tick();
        chk("switch_ack", 32'(bif.wr_ack), 1);
        dbg("switch_r3", 3'd3, 16'h0444);
        bif.rxIn = GR_NONE;
        tick();
        chk("switch_drop", 32'(bif.wr_ack), 0);

        // 5: multi-hot write, sticky err, clear, set-wins
        bif.rxIn = GR_R0 | GR_R1; bif.bus_in = 16'hDEAD;
        tick();
        chk("mh_err", 32'(bif.err), 1);
        chk("mh_ack", 32'(bif.wr_ack), 0);
        dbg("mh_r0", 3'd0, 16'h1234);
        dbg("mh_r1", 3'd1, 16'h0000);
        bif.rxIn = GR_NONE;
        tick();
        chk("err_sticky", 32'(bif.err), 1);
        bif.err_clr = 1'b1;
        tick();
        chk("err_clr", 32'(bif.err), 0);
        bif.rxOut = GR_R4 | GR_R5;
        #1;
        chk("mh_rd_drv", 32'(bif.bus_drv), 0);
        chk("mh_rd_bus", 32'(bif.bus_out), 0);
        tick();
        chk("err_setwins", 32'(bif.err), 1);
        bif.err_clr = 1'b0; bif.rxOut = GR_NONE;
        tick();
        chk("err_hold", 32'(bif.err), 1);

        // multi-hot while in WRITE returns to IDLE without ack or write
        bif.rxIn = GR_R5; bif.bus_in = 16'h0555;
        tick();
        chk("mhw_ack1", 32'(bif.wr_ack), 1);
        bif.rxIn = GR_R4 | GR_R5; bif.bus_in = 16'h0666;
        tick();
        chk("mhw_ack2", 32'(bif.wr_ack), 0);
        dbg("mhw_r5", 3'd5, 16'h0555);
        bif.rxIn = GR_R5; bif.bus_in = 16'h0777;
        tick();
        chk("mhw_ack3", 32'(bif.wr_ack), 1);
        dbg("mhw_r5b", 3'd5, 16'h0777);
        bif.rxIn = GR_NONE;
        tick();

        // 6: same register read and written in one cycle; debug out of range
        bif.rxIn = GR_R1; bif.bus_in = 16'h2222;
        tick();
        bif.rxIn = GR_NONE;
        tick();
        bif.rxOut = GR_R1; bif.rxIn = GR_R1; bif.bus_in = 16'hFFFF;
        #1;
        chk("same_old", 32'(bif.bus_out), 32'h2222);
        tick();
        chk("same_new", 32'(bif.bus_out), 32'hFFFF);
        bif.rxOut = GR_NONE; bif.rxIn = GR_NONE;
        dbg("dbg_sel7", 3'd7, 16'h0000);
        dbg("dbg_sel6", 3'd6, 16'h0000);
        tick();

        // reset asserted mid-cycle during a write: write lost, no ack
        bif.rxIn = GR_R3; bif.bus_in = 16'h9999;
        #2 rst = 1'b0;
        #1;
        dbg("mrst_r3", 3'd3, 16'h0000);
        dbg("mrst_r0", 3'd0, 16'h0000);
        chk("mrst_err", 32'(bif.err), 0);
        chk("mrst_ack", 32'(bif.wr_ack), 0);
        tick();
        chk("mrst_ack2", 32'(bif.wr_ack), 0);
        dbg("mrst_r3b", 3'd3, 16'h0000);
        bif.rxIn = GR_NONE;
        #2 rst = 1'b1;
        tick();
        chk("mrst_ack3", 32'(bif.wr_ack), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
